// File: rtl/cordic_ctrl_param.sv
// Iteration sequencer for the CORDIC x/y/z datapath: start/exec/done FSM,
// exported iteration index, latched mode and per-iteration rotation direction.
module cordic_ctrl_param #(
    parameter int ITR_W = 4,
    parameter int N_ITR = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             bgn,
    input  logic             mode_in,
    input  logic             cfg_en,
    input  logic [ITR_W-1:0] n_itr_in,
    input  logic             sign_in,
    input  logic             abort,
    input  logic             ack,
    output logic             init,
    output logic             ld,
    output logic             fin,
    output logic             busy,
    output logic [ITR_W-1:0] itr,
    output logic             mode,
    output logic             dir
);

    localparam logic [2:0]       S_IDLE    = 3'b001;
    localparam logic [2:0]       S_EXEC    = 3'b010;
    localparam logic [2:0]       S_DONE    = 3'b100;
    localparam logic [ITR_W-1:0] LAST_DFLT = ITR_W'(N_ITR - 1);
    localparam logic [ITR_W-1:0] ITR_ONE   = ITR_W'(1);

    logic [2:0]       st_q, st_d;
    logic [ITR_W-1:0] itr_q, itr_d;
    logic [ITR_W-1:0] last_q, last_d;
    logic             mode_q, mode_d;
    logic             busy_q;

    logic start;

    assign start = (st_q == S_IDLE) && bgn && !abort;

    // Strobes are combinational so the datapath sees them in the same cycle.
    always_comb begin
        init = 1'b0;
        ld   = 1'b0;
        fin  = 1'b0;
        case (st_q)
            S_IDLE: begin
                init = start;
                ld   = start;
            end
            S_EXEC:  ld  = !abort;
            S_DONE:  fin = !abort;
            default: ;
        endcase
    end

    always_comb begin
        st_d   = st_q;
        itr_d  = itr_q;
        last_d = last_q;
        mode_d = mode_q;
        case (st_q)
            S_IDLE: begin
                if (start) begin
                    st_d   = S_EXEC;
                    itr_d  = '0;
                    mode_d = mode_in;
                    last_d = cfg_en ? n_itr_in : LAST_DFLT;
                end
            end
            S_EXEC: begin
                if (abort) begin
                    st_d  = S_IDLE;
                    itr_d = '0;
                end else if (itr_q == last_q) begin
                    st_d = S_DONE;
                end else begin
                    itr_d = itr_q + ITR_ONE;
                end
            end
            S_DONE: begin
                if (abort) begin
                    st_d  = S_IDLE;
                    itr_d = '0;
                end else if (ack) begin
                    st_d = S_IDLE;
                end
            end
            default: begin
                st_d  = S_IDLE;
                itr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            st_q   <= S_IDLE;
            itr_q  <= '0;
            last_q <= LAST_DFLT;
            mode_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            itr_q  <= itr_d;
            last_q <= last_d;
            mode_q <= mode_d;
            busy_q <= (st_d != S_IDLE);
        end
    end

    assign busy = busy_q;
    assign itr  = itr_q;
    assign mode = mode_q;
    assign dir  = mode_q ? sign_in : ~sign_in;

endmodule

// File: tb/tb_cordic_ctrl_param.sv
// Directed bench for cordic_ctrl_param: table of full operations plus
// hand-written handshake, abort and asynchronous-reset sequences.
module tb_cordic_ctrl_param;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       bgn, mode_in, cfg_en, sign_in, abort, ack;
    logic [3:0] n_itr_in;
    logic       init, ld, fin, busy, mode, dir;
    logic [3:0] itr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cordic_ctrl_param #(.ITR_W(4), .N_ITR(16)) dut (
        .clk(clk), .rst_b(rst_b), .bgn(bgn), .mode_in(mode_in),
        .cfg_en(cfg_en), .n_itr_in(n_itr_in), .sign_in(sign_in),
        .abort(abort), .ack(ack), .init(init), .ld(ld), .fin(fin),
        .busy(busy), .itr(itr), .mode(mode), .dir(dir)
    );

    typedef struct {
        logic       cfg_en;
        logic [3:0] n_itr;
        logic       mode;
        logic       sign;
        int         iters;
        logic       exp_dir;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle 0 of an operation: bgn in IDLE, strobes rise combinationally.
    task automatic start_op(input logic c, input logic [3:0] n, input logic m, input logic s);
        @(posedge clk); #1;
        bgn = 1'b1; cfg_en = c; n_itr_in = n; mode_in = m; sign_in = s;
        abort = 1'b0; ack = 1'b0;
        #1;
        chk("start_init", init, 1'b1);
        chk("start_ld",   ld,   1'b1);
        chk("start_busy", busy, 1'b0);
        chk("start_fin",  fin,  1'b0);
    endtask

    // EXEC cycles; mode_in toggles each cycle to show the mode latch holds.
    task automatic run_exec(input int n, input logic exp_mode, input logic exp_dir);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bgn = 1'b0; mode_in = ~mode_in;
            #1;
            chk("exec_ld",   ld,   1'b1);
            chk("exec_init", init, 1'b0);
            chk("exec_fin",  fin,  1'b0);
            chk("exec_busy", busy, 1'b1);
            chk("exec_itr",  itr,  i);
            chk("exec_mode", mode, exp_mode);
            chk("exec_dir",  dir,  exp_dir);
        end
    endtask

    task automatic done_ack(input int last);
        @(posedge clk); #1;
        #1;
        chk("done_fin",  fin,  1'b1);
        chk("done_busy", busy, 1'b1);
        chk("done_ld",   ld,   1'b0);
        chk("done_itr",  itr,  last);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        #1;
        chk("idle_busy", busy, 1'b0);
        chk("idle_fin",  fin,  1'b0);
        chk("idle_ld",   ld,   1'b0);
    endtask

    initial begin
        tbl[0] = '{cfg_en: 1'b0, n_itr: 4'd0,  mode: 1'b0, sign: 1'b0, iters: 16, exp_dir: 1'b1};
        tbl[1] = '{cfg_en: 1'b1, n_itr: 4'd0,  mode: 1'b0, sign: 1'b1, iters: 1,  exp_dir: 1'b0};
        tbl[2] = '{cfg_en: 1'b1, n_itr: 4'd5,  mode: 1'b1, sign: 1'b1, iters: 6,  exp_dir: 1'b1};
        tbl[3] = '{cfg_en: 1'b1, n_itr: 4'd15, mode: 1'b1, sign: 1'b0, iters: 16, exp_dir: 1'b0};
        tbl[4] = '{cfg_en: 1'b0, n_itr: 4'd3,  mode: 1'b1, sign: 1'b1, iters: 16, exp_dir: 1'b1};
        tbl[5] = '{cfg_en: 1'b1, n_itr: 4'd2,  mode: 1'b0, sign: 1'b0, iters: 3,  exp_dir: 1'b1};

        rst_b = 1'b1; bgn = 1'b0; mode_in = 1'b0; cfg_en = 1'b0; n_itr_in = '0;
        sign_in = 1'b1; abort = 1'b0; ack = 1'b0;
        #12;
        chk("rst_init", init, 1'b0);
        chk("rst_ld",   ld,   1'b0);
        chk("rst_fin",  fin,  1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_itr",  itr,  4'd0);
        chk("rst_mode", mode, 1'b0);
        chk("rst_dir",  dir,  1'b0);
        rst_b = 1'b0;

        for (int v = 0; v < 6; v++) begin
            start_op(tbl[v].cfg_en, tbl[v].n_itr, tbl[v].mode, tbl[v].sign);
            run_exec(tbl[v].iters, tbl[v].mode, tbl[v].exp_dir);
            done_ack(tbl[v].iters - 1);
        end

        // Direction follows sign_in live: rotation mode gives dir = ~sign_in.
        start_op(1'b1, 4'd3, 1'b0, 1'b0);
        @(posedge clk); #1; bgn = 1'b0; sign_in = 1'b1; #1;
        chk("rot_dir_s1", dir, 1'b0);
        sign_in = 1'b0; #1;
        chk("rot_dir_s0", dir, 1'b1);
        @(posedge clk); #1; sign_in = 1'b1; #1;
        chk("rot_dir_itr1", dir, 1'b0);
        chk("rot_itr1", itr, 4'd1);
        @(posedge clk); @(posedge clk);
        done_ack(3);

        // Vectoring mode: dir = sign_in.
        start_op(1'b1, 4'd1, 1'b1, 1'b0);
        @(posedge clk); #1; bgn = 1'b0; mode_in = 1'b0; #1;
        chk("vec_dir_s0", dir, 1'b0);
        sign_in = 1'b1; #1;
        chk("vec_dir_s1", dir, 1'b1);
        chk("vec_mode", mode, 1'b1);
        @(posedge clk);
        done_ack(1);

        // Delayed ack with a stray bgn in DONE, then bgn held through ack.
        start_op(1'b1, 4'd1, 1'b0, 1'b0);
        run_exec(2, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            bgn = (k == 3);
            #1;
            chk("wait_fin",  fin,  1'b1);
            chk("wait_busy", busy, 1'b1);
            chk("wait_init", init, 1'b0);
            chk("wait_itr",  itr,  4'd1);
        end
        @(posedge clk); #1;
        bgn = 1'b1; mode_in = 1'b1; ack = 1'b1; sign_in = 1'b0;
        #1;
        chk("ack_fin", fin, 1'b1);
        @(posedge clk); #1;
        ack = 1'b0;
        #1;
        chk("restart_init", init, 1'b1);
        chk("restart_ld",   ld,   1'b1);
        chk("restart_busy", busy, 1'b0);
        run_exec(2, 1'b1, 1'b0);
        done_ack(1);

        // Abort at itr=7: ld drops that cycle, IDLE with itr=0 next, no fin.
        start_op(1'b0, 4'd0, 1'b0, 1'b0);
        run_exec(7, 1'b0, 1'b1);
        @(posedge clk); #1;
        abort = 1'b1;
        #1;
        chk("abort_itr",  itr,  4'd7);
        chk("abort_ld",   ld,   1'b0);
        chk("abort_fin",  fin,  1'b0);
        chk("abort_busy", busy, 1'b1);
        @(posedge clk); #1;
        abort = 1'b0;
        #1;
        chk("post_abort_busy", busy, 1'b0);
        chk("post_abort_itr",  itr,  4'd0);
        chk("post_abort_ld",   ld,   1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1; #1;
            chk("post_abort_nofin", fin, 1'b0);
        end

        // Abort together with ack in DONE.
        start_op(1'b1, 4'd0, 1'b0, 1'b0);
        run_exec(1, 1'b0, 1'b1);
        @(posedge clk); #1;
        abort = 1'b1; ack = 1'b1;
        #1;
        chk("abort_ack_fin", fin, 1'b0);
        @(posedge clk); #1;
        abort = 1'b0; ack = 1'b0;
        #1;
        chk("abort_ack_busy", busy, 1'b0);
        chk("abort_ack_itr",  itr,  4'd0);

        // Abort together with bgn in IDLE blocks the start.
        @(posedge clk); #1;
        bgn = 1'b1; abort = 1'b1;
        #1;
        chk("abort_bgn_init", init, 1'b0);
        chk("abort_bgn_ld",   ld,   1'b0);
        @(posedge clk); #1;
        bgn = 1'b0; abort = 1'b0;
        #1;
        chk("abort_bgn_busy", busy, 1'b0);
        chk("abort_bgn_ld2",  ld,   1'b0);

        // Asynchronous reset between edges at itr=3.
        start_op(1'b0, 4'd0, 1'b1, 1'b1);
        run_exec(3, 1'b1, 1'b1);
        @(posedge clk); #1; #1;
        chk("pre_rst_itr", itr, 4'd3);
        rst_b = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_itr",  itr,  4'd0);
        chk("arst_ld",   ld,   1'b0);
        chk("arst_init", init, 1'b0);
        chk("arst_fin",  fin,  1'b0);
        chk("arst_mode", mode, 1'b0);
        chk("arst_dir",  dir,  1'b0);
        @(negedge clk);
        rst_b = 1'b0;
        start_op(1'b1, 4'd4, 1'b0, 1'b1);
        run_exec(5, 1'b0, 1'b0);
        done_ack(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_ctrl_param.md
# cordic_ctrl_param

Parametrised control unit for the iterative CORDIC datapath. It sequences a configurable number of micro-rotations and exports the iteration index, so the datapath no longer supplies its own counter. It supports rotation and vectoring modes and derives the per-iteration rotation direction. The result is held valid under a fin/ack handshake, and an operation can be aborted. The block sits between the top-level command interface and the x/y/z register datapath.

## Interface
- `ITR_W`, default 4: width of the iteration index and of the count field.
- `N_ITR`, default 16: default iterations per operation. Legal range is 1 ≤ N_ITR ≤ 2^ITR_W.
- `clk` input, 1 bit: the single clock, rising edge.
- `rst_b` input, 1 bit: reset, asynchronous and active-high. `rst_b`=1 forces reset state immediately.
- `bgn` input, 1 bit: start request, sampled only in IDLE.
- `mode_in` input, 1 bit: 0 selects rotation (drive z to 0); 1 selects vectoring (drive y to 0). Latched at start.
- `cfg_en` input, 1 bit: 1 means use `n_itr_in` for this operation; 0 means use `N_ITR`. Latched at start.
- `n_itr_in` input, ITR_W bits: iteration count minus 1, so value k gives k+1 iterations.
- `sign_in` input, 1 bit: sign bit from the datapath. It is the sign of z in rotation mode and the sign of y in vectoring mode.
- `abort` input, 1 bit: cancels the operation in EXEC or DONE.
- `ack` input, 1 bit: consumer has taken the result.
- `init` output, 1 bit: load the operands into the datapath registers.
- `ld` output, 1 bit: register-load enable for the datapath.
- `fin` output, 1 bit: result valid, held until ack or abort.
- `busy` output, 1 bit: high in EXEC and DONE.
- `itr` output, ITR_W bits: current iteration index, used for the shift amount and the atan LUT address.
- `mode` output, 1 bit: latched mode.
- `dir` output, 1 bit: rotation direction for this iteration. 1 means +σ, 0 means −σ.

## Operation
- The state machine has three one-hot states: IDLE, EXEC and DONE.
- Internal registers:
  - `st`.
  - `itr`, ITR_W bits.
  - `last`, ITR_W bits.
  - `mode`.
- IDLE:
  - busy=0.
  - If bgn=1 and abort=0, init=1 and ld=1 combinationally in the same cycle.
  - On that edge: itr←0, mode←mode_in, last←(cfg_en ? n_itr_in : N_ITR−1), st←EXEC.
  - Otherwise all strobes are 0 and the state stays IDLE.
- EXEC:
  - ld=1 and init=0.
  - If itr==last, st←DONE and itr holds.
  - Otherwise itr←itr+1.
  - itr never wraps, because last ≤ 2^ITR_W−1.
- DONE:
  - fin=1 and ld=0.
  - itr holds last.
  - If ack=1, st←IDLE. Otherwise the state stays DONE and fin stays high.
  - bgn is ignored in DONE.
- Abort:
  - abort=1 in EXEC or DONE forces ld=0 and fin=0 in that cycle.
  - On that edge st←IDLE and itr←0.
  - In IDLE, abort=1 blocks bgn and no start occurs.
- Direction, combinational at all times: dir = mode ? sign_in : ~sign_in.
  - It is only meaningful when ld=1 and init=0.
- Simultaneous events:
  - abort has priority over ack and over bgn.
  - ack together with abort in DONE goes to IDLE, with fin=0 in that cycle.
  - A stable bgn held across DONE→IDLE starts a new operation in the first IDLE cycle.
- Reset:
  - Values: st=IDLE, itr=0, mode=0, last=N_ITR−1.
  - Resulting outputs: init=ld=fin=busy=0, itr=0, mode=0, dir=~sign_in.
  - Reset asserted mid-operation aborts immediately, with no fin pulse.
- Outputs init, ld and fin are combinational from st and the inputs. busy, itr and mode come directly from registers.

## Timing
- The start cycle is cycle 0, with bgn=1 in IDLE. In cycle 0, init=ld=1.
- EXEC occupies cycles 1..n, where n = last+1. In cycle i, itr=i−1 and ld=1.
- fin first goes high in cycle n+1, so latency from bgn to fin is n+1 cycles.
- With ack in cycle n+1, the block is in IDLE in cycle n+2. The minimum start-to-start period is n+2 cycles.
- With n=1, a single EXEC cycle has itr=0 and fin goes high in cycle 2.
- busy rises in cycle 1 and falls in the first IDLE cycle.

## Test plan
- **Default run.** Drive rst_b pulse, then bgn=1 for one cycle with cfg_en=0, N_ITR=16. Required: init=ld=1 in cycle 0; ld=1 with itr=0..15 in cycles 1..16; fin=1 from cycle 17 and held until ack.
- **Runtime count.** Drive cfg_en=1 and n_itr_in=0, then n_itr_in=5. Required: 1 EXEC cycle with fin in cycle 2; then 6 EXEC cycles with itr ending at 5 and fin in cycle 7.
- **Mode and direction.** Use mode_in=0 and toggle sign_in, then mode_in=1. Required: in rotation mode dir equals ~sign_in; in vectoring mode dir equals sign_in; mode output is latched and unaffected by mode_in changes during EXEC.
- **Handshake.**
  - Delay ack by 10 cycles: fin stays high and busy stays 1 throughout.
  - Pulse bgn while in DONE: it is ignored.
  - Hold bgn high through ack: a new operation starts in the first IDLE cycle.
- **Abort.**
  - abort at itr=7 gives ld=0 that cycle, IDLE next cycle with itr=0, and no fin.
  - abort together with ack in DONE gives fin=0 that cycle, then IDLE.
  - abort together with bgn in IDLE gives no start.
- **Async reset mid-EXEC.** Assert rst_b=1 between clock edges at itr=3. Required: st=IDLE and all outputs at reset values immediately, without waiting for a clock edge; after release, a normal run completes.
